csr_graph_builder: RTL and testbench

- Writer side of the BFS graph interface: turns a src-sorted edge stream into the CSR node-offset and edge-destination arrays that the BFS kernel reads.
- Sits between the host/DMA edge loader and the bfs kernel.
- Owns the graph storage and exposes a registered read port that the kernel indexes by node and by edge.
- Signals completion with `done` and a sticky `graph_valid`.

---
 rtl/bfs_pkg.sv | 24 ++
 rtl/csr_offset_rf.sv | 40 ++++
 rtl/csr_graph_builder.sv | 202 ++++++++++++++++++++
 tb/tb_csr_graph_builder.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bfs_pkg.sv
// Shared BFS graph constants, index types and the CSR builder state encoding.
// Used by the CSR graph builder and the BFS kernel.
package bfs_pkg;

  localparam int unsigned N_NODES     = 16;
  localparam int unsigned MAX_N_EDGES = 158;
  localparam int unsigned NODE_W      = $clog2(N_NODES);
  localparam int unsigned EDGE_W      = $clog2(MAX_N_EDGES + 1);
  localparam int unsigned MAX_LEVEL   = N_NODES - 1;

  typedef logic [NODE_W-1:0] node_idx_t;
  typedef logic [EDGE_W-1:0] edge_idx_t;
  // Offset table has N_NODES+1 entries, so its index needs one extra bit.
  typedef logic [NODE_W:0]   offset_idx_t;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StDrain,
    StFill,
    StDone
  } build_state_e;

endpackage

// File: rtl/csr_offset_rf.sv
// CSR node-offset register file: N_NODES+1 entries, one write port and a registered
// read pair returning offset[addr] and offset[addr+1].
module csr_offset_rf
  import bfs_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [NODE_W:0]   waddr,
  input  logic [EDGE_W-1:0] wdata,
  input  logic [NODE_W-1:0] raddr,
  output logic [EDGE_W-1:0] rdata_lo,
  output logic [EDGE_W-1:0] rdata_hi
);

  edge_idx_t   mem [N_NODES+1];
  offset_idx_t raddr_lo;
  offset_idx_t raddr_hi;

  assign raddr_lo = {1'b0, raddr};
  assign raddr_hi = raddr_lo + offset_idx_t'(1);

  // Storage is deliberately not reset; only the read registers are.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_lo <= '0;
      rdata_hi <= '0;
    end else begin
      rdata_lo <= mem[raddr_lo];
      rdata_hi <= mem[raddr_hi];
    end
  end

endmodule

// File: rtl/csr_graph_builder.sv
// Builds CSR offset/edge arrays from a src-sorted edge stream for the BFS kernel.
// Optional: define CSR_DROP_SELF_LOOP_EN to discard src==dst edges and count them.
module csr_graph_builder
  import bfs_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              edge_valid,
  output logic              edge_ready,
  input  logic [NODE_W-1:0] edge_src,
  input  logic [NODE_W-1:0] edge_dst,
  input  logic              edge_last,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              graph_valid,
  output logic [EDGE_W-1:0] n_edges,
  input  logic [NODE_W-1:0] rd_node,
  output logic [EDGE_W-1:0] node_begin,
  output logic [EDGE_W-1:0] node_end,
  input  logic [EDGE_W-1:0] rd_edge,
  output logic [NODE_W-1:0] edge_dst_q
`ifdef CSR_DROP_SELF_LOOP_EN
  ,
  output logic [EDGE_W-1:0] dropped_cnt
`endif
);

  build_state_e state_q, state_d;
  node_idx_t    cur_node_q, cur_node_d;
  edge_idx_t    edge_cnt_q, edge_cnt_d;
  logic         error_q, error_d;
  logic         graph_valid_q, graph_valid_d;
  edge_idx_t    n_edges_q, n_edges_d;
  edge_idx_t    dropped_q, dropped_d;

  logic         off_we;
  offset_idx_t  off_waddr;
  edge_idx_t    off_wdata;
  logic         mem_we;

  logic         src_eq;
  logic         dst_ok;
  logic         full;
  logic         self_loop;
  logic         beat_err;

  node_idx_t    edge_mem [MAX_N_EDGES];

  assign src_eq = (edge_src == cur_node_q);
  assign dst_ok = ({1'b0, edge_dst} < N_NODES[NODE_W:0]);
  assign full   = (edge_cnt_q == MAX_N_EDGES[EDGE_W-1:0]);
`ifdef CSR_DROP_SELF_LOOP_EN
  assign self_loop = (edge_src == edge_dst);
`else
  assign self_loop = 1'b0;
`endif
  // A dropped self-loop needs no storage, so it cannot overflow.
  assign beat_err = !dst_ok || (full && !self_loop);

  always_comb begin
    state_d       = state_q;
    cur_node_d    = cur_node_q;
    edge_cnt_d    = edge_cnt_q;
    error_d       = error_q;
    graph_valid_d = graph_valid_q;
    n_edges_d     = n_edges_q;
    dropped_d     = dropped_q;
    edge_ready    = 1'b0;
    off_we        = 1'b0;
    off_waddr     = {1'b0, cur_node_q} + offset_idx_t'(1);
    off_wdata     = edge_cnt_q;
    mem_we        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          off_we        = 1'b1;
          off_waddr     = '0;
          off_wdata     = '0;
          cur_node_d    = '0;
          edge_cnt_d    = '0;
          error_d       = 1'b0;
          graph_valid_d = 1'b0;
          dropped_d     = '0;
          state_d       = StLoad;
        end
      end
      StLoad: begin
        edge_ready = edge_valid && src_eq;
        if (edge_valid) begin
          if (edge_src > cur_node_q) begin
            // Close the current node; empty nodes end up with begin == end.
            off_we     = 1'b1;
            cur_node_d = cur_node_q + node_idx_t'(1);
          end else if (edge_src < cur_node_q) begin
            error_d = 1'b1;
            state_d = StDrain;
          end else begin
            if (beat_err) begin
              error_d = 1'b1;
            end else if (self_loop) begin
              dropped_d = dropped_q + edge_idx_t'(1);
            end else begin
              mem_we     = 1'b1;
              edge_cnt_d = edge_cnt_q + edge_idx_t'(1);
            end
            if (edge_last) begin
              state_d = StFill;
            end else if (beat_err) begin
              state_d = StDrain;
            end
          end
        end
      end
      StDrain: begin
        edge_ready = 1'b1;
        if (edge_valid && edge_last) begin
          state_d = StFill;
        end
      end
      StFill: begin
        off_we     = 1'b1;
        cur_node_d = cur_node_q + node_idx_t'(1);
        if (cur_node_q == node_idx_t'(N_NODES - 1)) begin
          // Publish results on entry to StDone so they are valid alongside the pulse.
          n_edges_d     = edge_cnt_q;
          graph_valid_d = !error_q;
          state_d       = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      cur_node_q    <= '0;
      edge_cnt_q    <= '0;
      error_q       <= 1'b0;
      graph_valid_q <= 1'b0;
      n_edges_q     <= '0;
      dropped_q     <= '0;
    end else begin
      state_q       <= state_d;
      cur_node_q    <= cur_node_d;
      edge_cnt_q    <= edge_cnt_d;
      error_q       <= error_d;
      graph_valid_q <= graph_valid_d;
      n_edges_q     <= n_edges_d;
      dropped_q     <= dropped_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      edge_mem[edge_cnt_q] <= edge_dst;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      edge_dst_q <= '0;
    end else if (rd_edge < MAX_N_EDGES[EDGE_W-1:0]) begin
      edge_dst_q <= edge_mem[rd_edge];
    end else begin
      edge_dst_q <= '0;
    end
  end

  csr_offset_rf u_offset_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (off_we),
    .waddr    (off_waddr),
    .wdata    (off_wdata),
    .raddr    (rd_node),
    .rdata_lo (node_begin),
    .rdata_hi (node_end)
  );

  assign busy        = (state_q == StLoad) || (state_q == StDrain) || (state_q == StFill);
  assign done        = (state_q == StDone);
  assign error       = error_q;
  assign graph_valid = graph_valid_q;
  assign n_edges     = n_edges_q;
`ifdef CSR_DROP_SELF_LOOP_EN
  assign dropped_cnt = dropped_q;
`else
  // Self-loop counter only exists as an output when dropping is enabled.
  logic unused_dropped;
  assign unused_dropped = ^dropped_q;
`endif

endmodule

// File: tb/tb_csr_graph_builder.sv
// Directed, table-driven bench for csr_graph_builder.
module tb_csr_graph_builder;
  import bfs_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              edge_valid;
  logic              edge_ready;
  logic [NODE_W-1:0] edge_src;
  logic [NODE_W-1:0] edge_dst;
  logic              edge_last;
  logic              busy;
  logic              done;
  logic              error;
  logic              graph_valid;
  logic [EDGE_W-1:0] n_edges;
  logic [NODE_W-1:0] rd_node;
  logic [EDGE_W-1:0] node_begin;
  logic [EDGE_W-1:0] node_end;
  logic [EDGE_W-1:0] rd_edge;
  logic [NODE_W-1:0] edge_dst_q;
`ifdef CSR_DROP_SELF_LOOP_EN
  logic [EDGE_W-1:0] dropped_cnt;
`endif

  always #5 clk = ~clk;

  csr_graph_builder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .edge_valid  (edge_valid),
    .edge_ready  (edge_ready),
    .edge_src    (edge_src),
    .edge_dst    (edge_dst),
    .edge_last   (edge_last),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .graph_valid (graph_valid),
    .n_edges     (n_edges),
    .rd_node     (rd_node),
    .node_begin  (node_begin),
    .node_end    (node_end),
    .rd_edge     (rd_edge),
    .edge_dst_q  (edge_dst_q)
`ifdef CSR_DROP_SELF_LOOP_EN
    ,
    .dropped_cnt (dropped_cnt)
`endif
  );

  typedef struct {
    int src;
    int dst;
    bit last;
    int exp_stalls;
  } beat_vec_t;

  typedef struct {
    int node;
    int exp_begin;
    int exp_end;
  } node_vec_t;

  typedef struct {
    int idx;
    int exp_dst;
  } edge_vec_t;

  beat_vec_t bq[$];
  node_vec_t nq[$];
  edge_vec_t eq[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_beat(input int src, input int dst, input bit last, output int stalls);
    bit acc;
    acc        = 1'b0;
    stalls     = 0;
    edge_valid = 1'b1;
    edge_src   = NODE_W'(src);
    edge_dst   = NODE_W'(dst);
    edge_last  = last;
    while (!acc && stalls < 64) begin
      #1;
      if (edge_ready) acc = 1'b1;
      else stalls++;
      tick();
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL beat_accept_timeout: got no accept, required accept within 64 cycles");
    end
    edge_valid = 1'b0;
    edge_last  = 1'b0;
  endtask

  task automatic run_beats(input string name);
    int st;
    foreach (bq[i]) begin
      send_beat(bq[i].src, bq[i].dst, bq[i].last, st);
      check($sformatf("%s_stall%0d", name, i), 32'(st), 32'(bq[i].exp_stalls));
    end
    bq.delete();
  endtask

  task automatic wait_done(input string name, input int exp_cycles, input bit exp_gv,
                           input int exp_n);
    int cyc;
    cyc = 0;
    while (!done && cyc < 100) begin
      tick();
      cyc++;
    end
    check({name, "_fill_cycles"}, 32'(cyc), 32'(exp_cycles));
    check({name, "_done"}, 32'(done), 32'd1);
    check({name, "_busy_at_done"}, 32'(busy), 32'd0);
    check({name, "_graph_valid"}, 32'(graph_valid), 32'(exp_gv));
    check({name, "_n_edges"}, 32'(n_edges), 32'(exp_n));
    tick();
    check({name, "_done_pulse"}, 32'(done), 32'd0);
    check({name, "_graph_valid_hold"}, 32'(graph_valid), 32'(exp_gv));
  endtask

  task automatic check_reads(input string name);
    foreach (nq[i]) begin
      rd_node = NODE_W'(nq[i].node);
      tick();
      check($sformatf("%s_begin%0d", name, nq[i].node), 32'(node_begin), 32'(nq[i].exp_begin));
      check($sformatf("%s_end%0d", name, nq[i].node), 32'(node_end), 32'(nq[i].exp_end));
    end
    foreach (eq[i]) begin
      rd_edge = EDGE_W'(eq[i].idx);
      tick();
      check($sformatf("%s_edge%0d", name, eq[i].idx), 32'(edge_dst_q), 32'(eq[i].exp_dst));
    end
    nq.delete();
    eq.delete();
  endtask

  task automatic load_basic_graph(input string name);
    bq.push_back('{0, 1, 1'b0, 0});
    bq.push_back('{0, 2, 1'b0, 0});
    run_beats({name, "_a"});
    // A start pulse mid-build must be ignored.
    pulse_start();
    check({name, "_busy_after_stray_start"}, 32'(busy), 32'd1);
    bq.push_back('{1, 3, 1'b0, 1});
    bq.push_back('{3, 0, 1'b1, 2});
    run_beats({name, "_b"});
    wait_done(name, 13, 1'b1, 4);
    nq.push_back('{0, 0, 2});
    nq.push_back('{1, 2, 3});
    nq.push_back('{2, 3, 3});
    nq.push_back('{3, 3, 4});
    nq.push_back('{4, 4, 4});
    nq.push_back('{15, 4, 4});
    eq.push_back('{0, 1});
    eq.push_back('{1, 2});
    eq.push_back('{2, 3});
    eq.push_back('{3, 0});
    check_reads(name);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    rst_n      = 1'b0;
    start      = 1'b0;
    edge_valid = 1'b1;
    edge_src   = '0;
    edge_dst   = '0;
    edge_last  = 1'b0;
    rd_node    = '0;
    rd_edge    = '0;
    tick();
    tick();
    // Reset state, with edge_valid held high to show IDLE never accepts.
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_graph_valid", 32'(graph_valid), 32'd0);
    check("rst_n_edges", 32'(n_edges), 32'd0);
    check("rst_edge_ready", 32'(edge_ready), 32'd0);
    check("rst_node_begin", 32'(node_begin), 32'd0);
    check("rst_node_end", 32'(node_end), 32'd0);
    check("rst_edge_dst_q", 32'(edge_dst_q), 32'd0);
    rst_n      = 1'b1;
    edge_valid = 1'b0;
    tick();
    check("idle_edge_ready", 32'(edge_ready), 32'd0);

    // Basic graph with an empty node and a stray start pulse.
    pulse_start();
    check("t1_busy", 32'(busy), 32'd1);
    load_basic_graph("t1");

    // Single beat from the highest node: 15 node-close stalls, one FILL cycle.
    pulse_start();
    bq.push_back('{15, 0, 1'b1, 15});
    run_beats("t2");
    wait_done("t2", 1, 1'b1, 1);
    nq.push_back('{0, 0, 0});
    nq.push_back('{7, 0, 0});
    nq.push_back('{14, 0, 0});
    nq.push_back('{15, 0, 1});
    eq.push_back('{0, 0});
    check_reads("t2");

    // Unsorted source: error after the second beat, rest drained.
    pulse_start();
    send_beat(2, 1, 1'b0, st);
    check("t3_stall0", 32'(st), 32'd2);
    check("t3_error_before", 32'(error), 32'd0);
    send_beat(1, 0, 1'b0, st);
    check("t3_stall1", 32'(st), 32'd1);
    check("t3_error_after", 32'(error), 32'd1);
    send_beat(3, 3, 1'b1, st);
    check("t3_stall2", 32'(st), 32'd0);
    wait_done("t3", 14, 1'b0, 1);
    check("t3_error_sticky", 32'(error), 32'd1);
    nq.push_back('{0, 0, 0});
    nq.push_back('{2, 0, 1});
    nq.push_back('{3, 1, 1});
    check_reads("t3");

    // Overflow: 159 beats on node 0, the last one cannot be stored.
    pulse_start();
    check("t4_error_cleared", 32'(error), 32'd0);
    for (int i = 0; i < 159; i++) begin
      send_beat(0, i % 16, (i == 158), st);
      if (i == 157) check("t4_error_at_cap", 32'(error), 32'd0);
    end
    check("t4_error_overflow", 32'(error), 32'd1);
    wait_done("t4", 16, 1'b0, 158);
    nq.push_back('{0, 0, 158});
    nq.push_back('{1, 158, 158});
    nq.push_back('{15, 158, 158});
    eq.push_back('{0, 0});
    eq.push_back('{157, 13});
    check_reads("t4");

    // Reset mid-LOAD aborts the build; a fresh build then succeeds.
    pulse_start();
    bq.push_back('{0, 1, 1'b0, 0});
    bq.push_back('{0, 2, 1'b0, 0});
    bq.push_back('{1, 3, 1'b0, 1});
    run_beats("t5");
    rst_n = 1'b0;
    tick();
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_error", 32'(error), 32'd0);
    check("t5_graph_valid", 32'(graph_valid), 32'd0);
    check("t5_n_edges", 32'(n_edges), 32'd0);
    rst_n = 1'b1;
    tick();
    check("t5_idle_busy", 32'(busy), 32'd0);
    pulse_start();
    load_basic_graph("t5r");

    // Self-loop edge.
    pulse_start();
    bq.push_back('{5, 5, 1'b1, 5});
    run_beats("t6");
`ifdef CSR_DROP_SELF_LOOP_EN
    wait_done("t6", 11, 1'b1, 0);
    check("t6_dropped", 32'(dropped_cnt), 32'd1);
    nq.push_back('{5, 0, 0});
    nq.push_back('{6, 0, 0});
`else
    wait_done("t6", 11, 1'b1, 1);
    nq.push_back('{4, 0, 0});
    nq.push_back('{5, 0, 1});
    nq.push_back('{6, 1, 1});
    eq.push_back('{0, 5});
`endif
    check_reads("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
